// File: rtl/if_id_inst_buffer.sv
// if_id_inst_buffer: in-order instruction queue between IF and ID.
// Captures {pc, inst, delay-slot tag} on every I-cache return and hands entries
// to decode over valid/ready. Flush (redirect) empties the queue in one cycle.
// Optional build macro IF_ADEL_CHECK_EN: adds id_adel, a per-entry misaligned-pc
// flag computed at push time.
module if_id_inst_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [31:0]       inst_pc,
    input  logic [31:0]       inst_data,
    input  logic              inst_dslot,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst,
    output logic              id_dslot,
    output logic              buf_full,
    output logic              buf_afull,
    output logic [ADDR_W:0]   buf_count,
    output logic              buf_ovf
`ifdef IF_ADEL_CHECK_EN
    ,
    output logic              id_adel
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AFULL_LV = (ADDR_W+1)'(DEPTH-1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        dslot;
`ifdef IF_ADEL_CHECK_EN
        logic        adel;
`endif
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_ovf;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W:0]   w_count;
    entry_t            w_head;
    entry_t            w_new;

    // Occupancy flags from pre-edge pointers; the extra MSB distinguishes full from empty.
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                  (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
        w_count = r_wr_ptr - r_rd_ptr;
        w_push  = inst_valid && !w_full && !flush;
        w_pop   = !w_empty && id_ready && !flush;
        w_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    end

    // Assemble the entry written on push (misalignment flag evaluated here, not at read).
    always_comb begin
        w_new       = '0;
        w_new.pc    = inst_pc;
        w_new.inst  = inst_data;
        w_new.dslot = inst_dslot;
`ifdef IF_ADEL_CHECK_EN
        w_new.adel  = (inst_pc[1:0] != 2'b00);
`endif
    end

    // Pointer and overflow state; flush outranks push/pop and clears the sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (inst_valid && w_full)
                r_ovf <= 1'b1;
        end
    end

    // Entry storage; flush leaves stale data in place, only reset zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_new;
        end
    end

    // Head presentation is a plain read of the entry at rd_ptr; no write bypass.
    always_comb begin
        id_valid  = !w_empty;
        id_pc     = w_head.pc;
        id_inst   = w_head.inst;
        id_dslot  = w_head.dslot;
        buf_full  = w_full;
        buf_afull = (w_count >= AFULL_LV);
        buf_count = w_count;
        buf_ovf   = r_ovf;
`ifdef IF_ADEL_CHECK_EN
        id_adel   = !w_empty && w_head.adel;
`endif
    end

endmodule

// File: tb/tb_if_id_inst_buffer.sv
// tb_if_id_inst_buffer: directed scenarios followed by random traffic, all checked
// against a queue-based model of the instruction buffer.
module tb_if_id_inst_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_valid;
    logic [31:0]       inst_pc;
    logic [31:0]       inst_data;
    logic              inst_dslot;
    logic              flush;
    logic              id_ready;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
    logic              id_dslot;
    logic              buf_full;
    logic              buf_afull;
    logic [ADDR_W:0]   buf_count;
    logic              buf_ovf;
`ifdef IF_ADEL_CHECK_EN
    logic              id_adel;
`endif

    always #5 clk = ~clk;

    if_id_inst_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .inst_data(inst_data), .inst_dslot(inst_dslot), .flush(flush),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_dslot(id_dslot), .buf_full(buf_full), .buf_afull(buf_afull),
        .buf_count(buf_count), .buf_ovf(buf_ovf)
`ifdef IF_ADEL_CHECK_EN
        , .id_adel(id_adel)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ds;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string w);
        int sz;
        sz = q.size();
        chk({w, ":valid"}, 64'(id_valid),  64'(sz != 0));
        chk({w, ":count"}, 64'(buf_count), 64'(sz));
        chk({w, ":full"},  64'(buf_full),  64'(sz == DEPTH));
        chk({w, ":afull"}, 64'(buf_afull), 64'(sz >= DEPTH-1));
        chk({w, ":ovf"},   64'(buf_ovf),   64'(m_ovf));
        if (sz != 0) begin
            chk({w, ":pc"},    64'(id_pc),    64'(q[0].pc));
            chk({w, ":inst"},  64'(id_inst),  64'(q[0].inst));
            chk({w, ":dslot"}, 64'(id_dslot), 64'(q[0].ds));
        end
`ifdef IF_ADEL_CHECK_EN
        chk({w, ":adel"}, 64'(id_adel), 64'(sz != 0 && q[0].pc[1:0] != 2'b00));
`endif
    endtask

    // One clock: drive inputs, advance the model with pre-edge occupancy, then compare.
    task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] data,
                        input bit ds, input bit fl, input bit rdy, input string w);
        int   sz;
        ent_t e;
        inst_valid = iv; inst_pc = pc; inst_data = data; inst_dslot = ds;
        flush = fl; id_ready = rdy;
        @(posedge clk);
        sz = q.size();
        if (reset || fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (rdy && sz > 0) e = q.pop_front();
            if (iv) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else begin
                    e.pc = pc; e.inst = data; e.ds = ds;
                    q.push_back(e);
                end
            end
        end
        #1;
        check_outs(w);
    endtask

    task automatic idle(input string w);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, w);
    endtask

    initial begin
        logic [31:0] p;
        reset = 1'b1;
        inst_valid = 0; inst_pc = 0; inst_data = 0; inst_dslot = 0; flush = 0; id_ready = 0;

        // Reset state
        idle("rst0");
        idle("rst1");
        reset = 1'b0;
        idle("rst_rel");
        chk("rst:id_pc",    64'(id_pc),    64'h0);
        chk("rst:id_inst",  64'(id_inst),  64'h0);
        chk("rst:id_dslot", 64'(id_dslot), 64'h0);

        // Fill to full, then overflow
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(i*4), 32'h1000_0001 + 32'(i), 1'b0, 1'b0, 1'b0, "fill");
        step(1'b1, 32'h10, 32'h1000_0005, 1'b0, 1'b0, 1'b0, "ovf");
        chk("ovf:count_is_4", 64'(buf_count), 64'd4);
        idle("ovf_hold");

        // Drain in order, then id_ready on empty is ignored
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "drain");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "empty_rdy");

        // Simultaneous push/pop at count 2, then wrap the pointers
        step(1'b1, 32'h18, 32'h2000_0001, 1'b1, 1'b0, 1'b0, "p2a");
        step(1'b1, 32'h1C, 32'h2000_0002, 1'b0, 1'b0, 1'b0, "p2b");
        step(1'b1, 32'h20, 32'h2000_0003, 1'b0, 1'b0, 1'b1, "pushpop");
        chk("pushpop:count2", 64'(buf_count), 64'd2);
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h24 + 32'(i*4), 32'h3000_0000 + 32'(i), 1'(i % 3 == 0),
                 1'b0, 1'b1, "wrap");

        // Flush with a concurrent instruction, then refill
        step(1'b1, 32'h50, 32'h4000_0001, 1'b0, 1'b0, 1'b0, "c3");
        step(1'b1, 32'h380, 32'hDEAD_0001, 1'b0, 1'b1, 1'b0, "flush");
        step(1'b1, 32'h380, 32'h4000_0380, 1'b0, 1'b0, 1'b0, "post_flush");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "pop_380");

        // Overflow then flush clears sticky bit
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h600 + 32'(i*4), 32'h5000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "ovf2");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "flush_ovf");

        // Misaligned pc and delay-slot tagging
        step(1'b1, 32'h0000_0402, 32'h6000_0001, 1'b0, 1'b0, 1'b0, "adel_a");
        step(1'b1, 32'h0000_0404, 32'h6000_0002, 1'b1, 1'b0, 1'b0, "adel_b");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "adel_pop1");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "adel_pop2");

        // Reset mid-operation discards everything and zeroes entries
        step(1'b1, 32'h700, 32'h7000_0001, 1'b1, 1'b0, 1'b0, "pre_rst");
        reset = 1'b1;
        idle("mid_rst");
        reset = 1'b0;
        idle("mid_rst_rel");
        chk("mid_rst:id_pc",   64'(id_pc),   64'h0);
        chk("mid_rst:id_inst", 64'(id_inst), 64'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            p = $urandom;
            if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), p, $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
